lsu_rv32: RTL and testbench

- Multi-cycle load/store unit for the RV32I core.
- Sits between the ALU address output and the writeback result mux; its `read_data` feeds the result mux's load input (`Res_Src` = 01).
- Drives a simple request/grant/response data-memory bus with byte strobes.
- Stalls the core while a transfer is outstanding, then aligns and sign-extends load data.

---
 rtl/lsu_pkg.sv | 53 +++++
 rtl/lsu_load_align.sv | 28 ++
 rtl/lsu_rv32.sv | 115 +++++++++++
 tb/tb_lsu_rv32.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 codes, FSM states,
// byte-strobe base masks and the store lane helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic is_legal(input logic we, input logic [2:0] funct3);
        if (we)
            return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
               (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            F3_H, F3_HU: return off[0];
            F3_W:        return off != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            F3_B, F3_BU: return STRB_B << off;
            F3_H, F3_HU: return STRB_H << off;
            default:     return STRB_W;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] wdata);
        case (funct3)
            F3_B:    return {4{wdata[7:0]}};
            F3_H:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword lane of a read word and sign- or
// zero-extends it according to the load funct3.
module lsu_load_align (
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    output logic [31:0] result
);
    import lsu_pkg::*;

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[{off, 3'b000} +: 8];
        half_v = off[1] ? rdata[31:16] : rdata[15:0];
        result = '0;
        case (funct3)
            F3_B:    result = {{24{byte_v[7]}}, byte_v};
            F3_H:    result = {{16{half_v[15]}}, half_v};
            F3_W:    result = rdata;
            F3_BU:   result = {24'd0, byte_v};
            F3_HU:   result = {16'd0, half_v};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/lsu_rv32.sv
// Multi-cycle RV32I load/store unit: stalls the core across a request/grant/
// response data-memory transfer and returns aligned, extended load data.
module lsu_rv32 #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] read_data,
    output logic        fault,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    import lsu_pkg::*;

    state_t             state;
    logic [2:0]         cap_f3;
    logic [1:0]         cap_off;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               bad_req;
    logic               issue;
    logic [31:0]        load_result;

    lsu_load_align u_load_align (
        .rdata  (mem_rdata),
        .funct3 (cap_f3),
        .off    (cap_off),
        .result (load_result)
    );

    always_comb begin
        bad_req  = is_misaligned(req_funct3, req_addr[1:0]) || !is_legal(req_we, req_funct3);
        fault    = req_valid && (state == IDLE) && bad_req;
        issue    = req_valid && (state == IDLE) && !bad_req;
        stall    = issue || (state == REQ) || (state == WAIT);
        cnt_next = cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wstrb <= '0;
            mem_wdata <= '0;
            read_data <= '0;
            done      <= 1'b0;
            bus_err   <= 1'b0;
            cnt       <= '0;
            cap_f3    <= '0;
            cap_off   <= '0;
        end else begin
            done    <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        cap_f3    <= req_funct3;
                        cap_off   <= req_addr[1:0];
                        mem_we    <= req_we;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_wstrb <= store_strb(req_funct3, req_addr[1:0]);
                        mem_wdata <= store_data(req_funct3, req_wdata);
                        mem_req   <= 1'b1;
                        state     <= REQ;
                    end
                end
                // rvalid coincident with grant is deliberately not looked at here
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        cnt     <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        if (!mem_we)
                            read_data <= load_result;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (cnt_next == CNT_W'(TIMEOUT)) begin
                        cnt <= cnt_next;
                        if (!mem_we)
                            read_data <= '0;
                        done    <= 1'b1;
                        bus_err <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_rv32.sv
// Directed bench for lsu_rv32: a table of single transfers plus hand-written
// sequences for delayed grant, grant/rvalid overlap, timeout and reset.
module tb_lsu_rv32;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic [31:0] read_data;
    logic        fault;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    lsu_rv32 #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .done       (done),
        .read_data  (read_data),
        .fault      (fault),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exp_fault;
        logic [31:0] exp_rd;
        logic [31:0] exp_maddr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        issue(v.we, v.f3, v.addr, v.wdata);
        #1;
        check($sformatf("v%0d fault", idx), fault, v.exp_fault);
        check($sformatf("v%0d issue_stall", idx), stall, !v.exp_fault);
        if (v.exp_fault) begin
            @(negedge clk);
            check($sformatf("v%0d no_req", idx), mem_req, 0);
            check($sformatf("v%0d rd_hold", idx), read_data, v.exp_rd);
            req_valid = 1'b0;
        end else begin
            @(negedge clk);
            check($sformatf("v%0d req", idx), mem_req, 1);
            check($sformatf("v%0d we", idx), mem_we, v.we);
            check($sformatf("v%0d addr", idx), mem_addr, v.exp_maddr);
            if (v.we) begin
                check($sformatf("v%0d wstrb", idx), mem_wstrb, v.exp_strb);
                check($sformatf("v%0d wdata", idx), mem_wdata, v.exp_wdata);
            end
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
            check($sformatf("v%0d req_drop", idx), mem_req, 0);
            check($sformatf("v%0d wait_stall", idx), stall, 1);
            mem_rvalid = 1'b1;
            mem_rdata  = v.rdata;
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            check($sformatf("v%0d done", idx), done, 1);
            check($sformatf("v%0d bus_err", idx), bus_err, 0);
            check($sformatf("v%0d done_stall", idx), stall, 0);
            check($sformatf("v%0d read_data", idx), read_data, v.exp_rd);
            @(negedge clk);
            check($sformatf("v%0d no_reissue", idx), mem_req, 0);
            check($sformatf("v%0d done_pulse", idx), done, 0);
            req_valid = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          we    f3      addr          wdata         rdata         flt   exp_rd        maddr         strb     wdata
        vecs[0]  = '{1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 1'b0, 32'hFFFF_FF80, 32'h0000_1000, 4'b0000, 32'h0};
        vecs[1]  = '{1'b0, 3'b101, 32'h0000_2002, 32'h0,        32'hBEEF_0000, 1'b0, 32'h0000_BEEF, 32'h0000_2000, 4'b0000, 32'h0};
        vecs[2]  = '{1'b0, 3'b001, 32'h0000_2002, 32'h0,        32'hBEEF_0000, 1'b0, 32'hFFFF_BEEF, 32'h0000_2000, 4'b0000, 32'h0};
        vecs[3]  = '{1'b0, 3'b100, 32'h0000_1001, 32'h0,        32'h80FF_1234, 1'b0, 32'h0000_0012, 32'h0000_1000, 4'b0000, 32'h0};
        vecs[4]  = '{1'b0, 3'b000, 32'h0000_1002, 32'h0,        32'h80FF_1234, 1'b0, 32'hFFFF_FFFF, 32'h0000_1000, 4'b0000, 32'h0};
        vecs[5]  = '{1'b0, 3'b101, 32'h0000_2000, 32'h0,        32'hBEEF_1357, 1'b0, 32'h0000_1357, 32'h0000_2000, 4'b0000, 32'h0};
        vecs[6]  = '{1'b0, 3'b010, 32'h0000_4000, 32'h0,        32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 32'h0000_4000, 4'b0000, 32'h0};
        vecs[7]  = '{1'b1, 3'b000, 32'h0000_3001, 32'h0000_00AB, 32'hFFFF_FFFF, 1'b0, 32'hDEAD_BEEF, 32'h0000_3000, 4'b0010, 32'hABAB_ABAB};
        vecs[8]  = '{1'b1, 3'b001, 32'h0000_3002, 32'h1234_CAFE, 32'hFFFF_FFFF, 1'b0, 32'hDEAD_BEEF, 32'h0000_3000, 4'b1100, 32'hCAFE_CAFE};
        vecs[9]  = '{1'b1, 3'b010, 32'h0000_3004, 32'h0123_4567, 32'hFFFF_FFFF, 1'b0, 32'hDEAD_BEEF, 32'h0000_3004, 4'b1111, 32'h0123_4567};
        vecs[10] = '{1'b0, 3'b010, 32'h0000_4002, 32'h0,        32'h0,         1'b1, 32'hDEAD_BEEF, 32'h0,         4'b0000, 32'h0};
        vecs[11] = '{1'b0, 3'b011, 32'h0000_4000, 32'h0,        32'h0,         1'b1, 32'hDEAD_BEEF, 32'h0,         4'b0000, 32'h0};
        vecs[12] = '{1'b1, 3'b100, 32'h0000_3000, 32'h0,        32'h0,         1'b1, 32'hDEAD_BEEF, 32'h0,         4'b0000, 32'h0};
        vecs[13] = '{1'b0, 3'b001, 32'h0000_2001, 32'h0,        32'h0,         1'b1, 32'hDEAD_BEEF, 32'h0,         4'b0000, 32'h0};
        vecs[14] = '{1'b1, 3'b010, 32'h0000_3006, 32'h0,        32'h0,         1'b1, 32'hDEAD_BEEF, 32'h0,         4'b0000, 32'h0};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        @(negedge clk);
        @(negedge clk);
        check("rst mem_req", mem_req, 0);
        check("rst mem_we", mem_we, 0);
        check("rst done", done, 0);
        check("rst bus_err", bus_err, 0);
        check("rst wstrb", mem_wstrb, 0);
        check("rst addr", mem_addr, 0);
        check("rst wdata", mem_wdata, 0);
        check("rst read_data", read_data, 0);
        check("rst stall", stall, 0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++)
            run_vec(vecs[i], i);

        // SB with grant held off for three cycles
        @(negedge clk);
        issue(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00AB);
        #1;
        check("dly issue_stall", stall, 1);
        @(negedge clk);
        req_addr  = 32'h0000_7777;
        req_wdata = 32'h5555_5555;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("dly%0d req", i), mem_req, 1);
            check($sformatf("dly%0d addr", i), mem_addr, 32'h0000_3000);
            check($sformatf("dly%0d wstrb", i), mem_wstrb, 4'b0010);
            check($sformatf("dly%0d wdata", i), mem_wdata, 32'hABAB_ABAB);
            check($sformatf("dly%0d we", i), mem_we, 1);
            check($sformatf("dly%0d stall", i), stall, 1);
            if (i == 3)
                mem_gnt = 1'b1;
            else
                @(negedge clk);
        end
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("dly done", done, 1);
        check("dly rd_hold", read_data, 32'hDEAD_BEEF);
        req_valid = 1'b0;

        // rvalid arriving in the grant cycle is not accepted
        @(negedge clk);
        issue(1'b0, 3'b010, 32'h0000_6000, 32'h0);
        @(negedge clk);
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h9999_9999;
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        check("ovl no_done", done, 0);
        check("ovl stall", stall, 1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1122_3344;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("ovl done", done, 1);
        check("ovl read_data", read_data, 32'h1122_3344);
        req_valid = 1'b0;

        // rvalid never arrives: abort after four WAIT cycles
        @(negedge clk);
        issue(1'b0, 3'b010, 32'h0000_5000, 32'h0);
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("to%0d stall", i), stall, 1);
            check($sformatf("to%0d no_done", i), done, 0);
            @(negedge clk);
        end
        check("to done", done, 1);
        check("to bus_err", bus_err, 1);
        check("to read_data", read_data, 0);
        check("to stall", stall, 0);
        @(negedge clk);
        check("to done_pulse", done, 0);
        check("to bus_err_pulse", bus_err, 0);
        req_valid = 1'b0;

        run_vec('{1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 1'b0,
                  32'hCAFE_F00D, 32'h0000_4000, 4'b0000, 32'h0}, 15);

        // reset while waiting for the response; a late rvalid must be ignored
        @(negedge clk);
        issue(1'b0, 3'b010, 32'h0000_7000, 32'h0);
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt   = 1'b0;
        rst       = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rw mem_req", mem_req, 0);
        check("rw stall", stall, 0);
        check("rw read_data", read_data, 0);
        check("rw done", done, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_FFFF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("rw late_done", done, 0);
        check("rw late_stall", stall, 0);
        check("rw late_rd", read_data, 0);
        @(negedge clk);
        check("rw late_done2", done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
